// File: rtl/modexp_seq.sv
// Left-to-right square-and-multiply sequencer for the shared modular multiplier.
// Optional macro MODEXP_SKIP_LEADING_ZEROS_EN skips squarings of 1 before the first set exponent bit.
module modexp_seq #(
   parameter int E_W   = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [E_W-1:0]   exp,
   input  logic             mul_done,
   output logic             mul_start,
   output logic             b_sel,
   output logic             res_load,
   output logic             res_sel,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] mul_cnt
);

   localparam int IDX_W = (E_W > 1) ? $clog2(E_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(E_W - 1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SQ_START,
      S_SQ_WAIT,
      S_MUL_START,
      S_MUL_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [E_W-1:0]   exp_q, exp_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             cur_bit;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
   logic             lead_q, lead_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         exp_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
         lead_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
         lead_q  <= lead_d;
`endif
      end
   end

   assign cur_bit = exp_q[idx_q];
   // Saturating count keeps the last value visible on long exponents
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
   assign mul_cnt = cnt_q;

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      lead_d    = lead_q;
`endif
      mul_start = 1'b0;
      b_sel     = 1'b0;
      res_load  = 1'b0;
      res_sel   = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               exp_d   = exp;
               idx_d   = IDX_TOP;
               cnt_d   = '0;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
               lead_d  = 1'b1;
`endif
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            res_load = 1'b1;
            state_d  = S_SQ_START;
         end
         S_SQ_START: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            if (lead_q) begin
               if (cur_bit) begin
                  lead_d  = 1'b0;
                  state_d = S_MUL_START;
               end else begin
                  state_d = S_NEXT;
               end
            end else begin
`endif
               mul_start = 1'b1;
               cnt_d     = cnt_inc;
               state_d   = S_SQ_WAIT;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            end
`endif
         end
         S_SQ_WAIT: begin
            res_sel = 1'b1;
            if (mul_done) begin
               res_load = 1'b1;
               state_d  = cur_bit ? S_MUL_START : S_NEXT;
            end
         end
         S_MUL_START: begin
            mul_start = 1'b1;
            b_sel     = 1'b1;
            cnt_d     = cnt_inc;
            state_d   = S_MUL_WAIT;
         end
         S_MUL_WAIT: begin
            b_sel   = 1'b1;
            res_sel = 1'b1;
            if (mul_done) begin
               res_load = 1'b1;
               state_d  = S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx_q == '0) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q - IDX_ONE;
               state_d = S_SQ_START;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_modexp_seq.sv
// Directed bench for modexp_seq with a behavioural multiplier of programmable latency.
// Expected values switch with MODEXP_SKIP_LEADING_ZEROS_EN.
module tb_modexp_seq;

   localparam int E_W   = 4;
   localparam int CNT_W = 3;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
   localparam int D1 = 19, P1 = 6, B1 = 'b100101, C1 = 6;
   localparam int D2 = 10, P2 = 0, B2 = 0, C2 = 0;
   localparam int D3 = 20, P3 = 4, B3 = 'b1001, C3 = 4;
   localparam int D4 = 21, P4 = 7, B4 = 'b1010101, C4 = 7;
   localparam int AB = 5, PA = 1;
   localparam int D6 = 31;
`else
   localparam int D1 = 20, P1 = 7, B1 = 'b0100101, C1 = 7;
   localparam int D2 = 22, P2 = 4, B2 = 0, C2 = 4;
   localparam int D3 = 24, P3 = 6, B3 = 'b001001, C3 = 6;
   localparam int D4 = 22, P4 = 8, B4 = 'b01010101, C4 = 7;
   localparam int AB = 10, PA = 2;
   localparam int D6 = 32;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [E_W-1:0]   exp_in;
   logic             mul_done;
   logic             mul_start;
   logic             b_sel;
   logic             res_load;
   logic             res_sel;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] mul_cnt;

   int errs   = 0;
   int checks = 0;

   modexp_seq #(.E_W(E_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .exp       (exp_in),
      .mul_done  (mul_done),
      .mul_start (mul_start),
      .b_sel     (b_sel),
      .res_load  (res_load),
      .res_sel   (res_sel),
      .busy      (busy),
      .done      (done),
      .mul_cnt   (mul_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // One operation from its cycle 0 (caller sits just after a rising edge).
   // lmode 1 alternates latency 1/5, otherwise lfix. Returns at the
   // falling edge of the DONE cycle (or of the abort cycle).
   task automatic run_op(input logic [E_W-1:0] e, input int lmode,
                         input int lfix, input bit spur, input bit hold,
                         input int abort_at, output int dcyc,
                         output int npulse, output logic [15:0] bseq,
                         output int viol, output int cnt);
      int   k    = 0;
      bit   pend = 1'b0;
      int   due  = 0;
      logic hb   = 1'b0;
      logic md;
      dcyc   = -1;
      npulse = 0;
      bseq   = '0;
      viol   = 0;
      cnt    = -1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         md       = pend && (due == cyc);
         mul_done = md || (spur && !pend);
         start    = hold || (cyc == 0) || (spur && pend);
         exp_in   = (cyc == 0) ? e : ~e;
         rst_n    = (cyc != abort_at);
         @(negedge clk);
         if (busy !== (cyc != 0)) viol++;
         if (res_load !== ((cyc == 1) || md)) viol++;
         if (res_sel !== pend) viol++;
         if (pend && (b_sel !== hb)) viol++;
         if (md) pend = 1'b0;
         if (mul_start === 1'b1) begin
            if (pend) viol++;
            npulse++;
            bseq = {bseq[14:0], b_sel};
            hb   = b_sel;
            pend = 1'b1;
            due  = cyc + ((lmode == 1) ? ((k % 2 == 0) ? 1 : 5) : lfix);
            k++;
         end
         if (done === 1'b1) begin
            dcyc = cyc;
            cnt  = int'(mul_cnt);
            break;
         end
         if (cyc == abort_at) begin
            dcyc = -2;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!hold) start = 1'b0;
      mul_done = 1'b0;
   endtask

   task automatic step_idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          d, p, v, c, bad;
      logic [15:0] bs;
      rst_n    = 1'b0;
      start    = 1'b0;
      mul_done = 1'b0;
      exp_in   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.mul_start", mul_start, 0);
      chk("rst.b_sel", b_sel, 0);
      chk("rst.res_load", res_load, 0);
      chk("rst.res_sel", res_sel, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.mul_cnt", mul_cnt, 0);
      rst_n = 1'b1;
      step_idle();

      run_op(4'b1011, 0, 1, 1'b0, 1'b0, -1, d, p, bs, v, c);
      chk("t1.done_cyc", d, D1);
      chk("t1.pulses", p, P1);
      chk("t1.bsel_seq", bs, B1);
      chk("t1.mul_cnt", c, C1);
      chk("t1.viol", v, 0);
      repeat (3) step_idle();
      @(negedge clk);
      chk("t1.cnt_hold", mul_cnt, C1);
      chk("t1.idle_busy", busy, 0);
      step_idle();

      run_op(4'b0000, 0, 3, 1'b0, 1'b1, -1, d, p, bs, v, c);
      chk("t2a.done_cyc", d, D2);
      chk("t2a.pulses", p, P2);
      chk("t2a.mul_cnt", c, C2);
      chk("t2a.viol", v, 0);
      step_idle();
      run_op(4'b0000, 0, 3, 1'b0, 1'b1, -1, d, p, bs, v, c);
      start = 1'b0;
      chk("t2b.done_cyc", d, D2);
      chk("t2b.bsel_seq", bs, B2);
      chk("t2b.mul_cnt", c, C2);
      chk("t2b.viol", v, 0);
      step_idle();

      run_op(4'b0101, 0, 2, 1'b1, 1'b0, -1, d, p, bs, v, c);
      chk("t3.done_cyc", d, D3);
      chk("t3.pulses", p, P3);
      chk("t3.bsel_seq", bs, B3);
      chk("t3.mul_cnt", c, C3);
      chk("t3.viol", v, 0);
      step_idle();

      run_op(4'b1111, 0, 1, 1'b0, 1'b0, -1, d, p, bs, v, c);
      chk("t4.done_cyc", d, D4);
      chk("t4.pulses", p, P4);
      chk("t4.bsel_seq", bs, B4);
      chk("t4.mul_cnt_sat", c, C4);
      chk("t4.viol", v, 0);
      step_idle();

      run_op(4'b1011, 0, 5, 1'b0, 1'b0, AB, d, p, bs, v, c);
      chk("t5.aborted", d, -2);
      chk("t5.pulses", p, PA);
      chk("t5.viol", v, 0);
      step_idle();
      rst_n    = 1'b1;
      mul_done = 1'b1;
      @(negedge clk);
      chk("t5.mul_start", mul_start, 0);
      chk("t5.b_sel", b_sel, 0);
      chk("t5.res_load", res_load, 0);
      chk("t5.res_sel", res_sel, 0);
      chk("t5.busy", busy, 0);
      chk("t5.done", done, 0);
      chk("t5.mul_cnt", mul_cnt, 0);
      step_idle();
      mul_done = 1'b0;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
         step_idle();
      end
      chk("t5.quiet", bad, 0);
      run_op(4'b1011, 0, 1, 1'b0, 1'b0, -1, d, p, bs, v, c);
      chk("t5r.done_cyc", d, D1);
      chk("t5r.mul_cnt", c, C1);
      chk("t5r.viol", v, 0);
      step_idle();

      run_op(4'b1011, 1, 1, 1'b0, 1'b0, -1, d, p, bs, v, c);
      chk("t6.done_cyc", d, D6);
      chk("t6.pulses", p, P1);
      chk("t6.bsel_seq", bs, B1);
      chk("t6.mul_cnt", c, C1);
      chk("t6.viol", v, 0);
      step_idle();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
